cam_acc_avalon_csr: RTL
=======================

// Module: cam_acc_avalon_csr
// PURPOSE
// Parametrised Avalon-MM slave CSR block between the HPS and the camera/MNIST accelerator datapath.
// Exposes a word-addressed register map, a host pixel read port with auto-increment and waitrequest stall,
// and a go/busy/done accelerator handshake with sticky done and level IRQ. Owns the frame-buffer read
// address mux: the host pointer drives it when idle, the accelerator's image index drives it when busy.
// PARAMETERS
// DATA_W     32  Avalon data width; legal values 8, 16, 32; register fields wider than DATA_W are truncated
// PIX_AW     16  frame-buffer pixel address width
// PIX_W       8  pixel width, zero-extended to DATA_W on read
// MEM_LAT     1  frame-buffer read latency in cycles, 1..4
// LAYER_W     3  accelerator layer index width
// DONE_W      3  accelerator done-code width
// PORTS
// clk                  in   1        system clock; sole clock of the block
// rst_n                in   1        asynchronous active-low reset
// avs_address          in   3        word address
// avs_chipselect       in   1        slave select
// avs_read             in   1        read strobe
// avs_write            in   1        write strobe
// avs_writedata        in   DATA_W   write data
// avs_readdata         out  DATA_W   read data, registered
// avs_waitrequest      out  1        stall; high only during a PIX_DATA read in flight
// irq                  out  1        level interrupt = done_sticky & irq_en
// button_count         in   8        capture count from camera_interface
// pix_addr             out  PIX_AW   frame-buffer read address
// pix_data             in   PIX_W    frame-buffer read data, valid MEM_LAT cycles after pix_addr
// acc_image_idx        in   PIX_AW   accelerator pixel index
// acc_go               out  1        one-cycle start pulse
// acc_layer_index      out  LAYER_W  layer select
// acc_data_address     out  16       data base address
// acc_weight_address   out  16       weight base address
// acc_done             in   DONE_W   nonzero = layer finished (code)
// BEHAVIOUR
// Reset: all registers, avs_readdata, irq, acc_go, pix_addr = 0; avs_waitrequest = 0; FSMs in IDLE.
// Map: 0 STATUS(RO){err,done_sticky,busy} 1 CTRL(RW){irq_en[2],autoinc[1]; W1 to bit0 = go}
//   2 PIX_PTR(RW) 3 PIX_DATA(RO) 4 LAYER(RW) 5 DATA_ADDR(RW) 6 WEIGHT_ADDR(RW) 7 BUTTON_COUNT(RO).
// Writes to RO/unused bits ignored; writes of STATUS with bit1 set clear done_sticky and err.
// Non-PIX_DATA reads: readdata updated the cycle after the strobe, waitrequest stays low.
// Host pixel FSM: IDLE -> PIX_WAIT on read@3 (not busy); waitrequest=1 from the strobe cycle for MEM_LAT+1
//   cycles; RESP: readdata = zero-ext pix_data, waitrequest=0; if autoinc, PIX_PTR += 1 mod 2^PIX_AW -> IDLE.
// PIX_DATA read while busy: no stall, readdata = 0, err set sticky.
// Write to PIX_PTR during PIX_WAIT is stalled (waitrequest held) until RESP completes.
// Acc FSM: IDLE -go-> GO (acc_go=1 one cycle, busy=1) -> BUSY until acc_done!=0 -> DONE: latch code
//   into STATUS[7:5], done_sticky=1 -> IDLE. go while busy ignored and sets err.
// Address mux: pix_addr = busy ? acc_image_idx : PIX_PTR, registered? no: combinational from regs.
// acc_layer_index/data/weight addresses are register outputs, frozen (writes ignored) while busy.
// Simultaneous done-set and W1C in same cycle: set wins.
// Reset mid-operation: all FSMs return to IDLE immediately; pending Avalon read is abandoned.
// DATA_W=8: DATA_ADDR/WEIGHT_ADDR/PIX_PTR split into low/high bytes at addresses 5/6/2 low,
//   upper byte via CTRL bit7 page select; 16/32 use single words.
// TESTING
// Reset: rst_n=0 mid PIX_WAIT -> waitrequest=0, readdata=0, pix_addr=0 immediately.
// PIX_PTR=0xFFFF, autoinc=1, mem[0xFFFF]=0xA5, read@3 -> waitrequest 2 cycles (MEM_LAT=1), data 0xA5, ptr 0x0000.
// go with LAYER=3, acc_done=3'b010 after 50 cycles -> acc_go one pulse, busy 51 cycles, STATUS done=1, code=2.
// irq_en=1, done set -> irq=1; write STATUS bit1 -> irq=0 next cycle; concurrent done wins.
// Read@3 while busy -> readdata 0, no stall, err=1; pix_addr tracks acc_image_idx.
// Rerun DATA_W=8: byte-paged write 0x1234 to DATA_ADDR -> acc_data_address=0x1234.

Source files
------------

// File: rtl/cam_acc_avalon_csr.sv
// cam_acc_avalon_csr
// Avalon-MM CSR slave between the HPS and the camera/MNIST accelerator.
// Word map: 0 STATUS, 1 CTRL, 2 PIX_PTR, 3 PIX_DATA, 4 LAYER,
//           5 DATA_ADDR, 6 WEIGHT_ADDR, 7 BUTTON_COUNT.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   avs_*                           Avalon-MM slave (registered readdata, waitrequest stall)
//   irq                             level interrupt, done_sticky & irq_en
//   button_count                    capture count, read-only at address 7
//   pix_addr / pix_data             frame-buffer read port (MEM_LAT-cycle read latency)
//   acc_image_idx                   accelerator pixel index, drives pix_addr while busy
//   acc_go / acc_layer_index /
//   acc_data_address /
//   acc_weight_address / acc_done   accelerator handshake and configuration
//
// Pixel FSM
//   state     | meaning
//   PIX_IDLE  | no host pixel read in flight
//   PIX_WAIT  | waiting MEM_LAT cycles for frame-buffer data
//   PIX_RESP  | readdata holds the pixel, stall released
// Accelerator FSM
//   state     | meaning
//   ACC_IDLE  | ready for go
//   ACC_GO    | one-cycle acc_go pulse
//   ACC_BUSY  | waiting for nonzero acc_done
//   ACC_DONE  | code latched, returning to idle
module cam_acc_avalon_csr #(
  parameter int DATA_W  = 32,
  parameter int PIX_AW  = 16,
  parameter int PIX_W   = 8,
  parameter int MEM_LAT = 1,
  parameter int LAYER_W = 3,
  parameter int DONE_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         avs_address,
  input  logic               avs_chipselect,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [DATA_W-1:0]  avs_writedata,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_waitrequest,
  output logic               irq,
  input  logic [7:0]         button_count,
  output logic [PIX_AW-1:0]  pix_addr,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic [PIX_AW-1:0]  acc_image_idx,
  output logic               acc_go,
  output logic [LAYER_W-1:0] acc_layer_index,
  output logic [15:0]        acc_data_address,
  output logic [15:0]        acc_weight_address,
  input  logic [DONE_W-1:0]  acc_done
);

  typedef enum logic [1:0] {PIX_IDLE, PIX_WAIT, PIX_RESP} pix_state_t;
  typedef enum logic [1:0] {ACC_IDLE, ACC_GO, ACC_BUSY, ACC_DONE} acc_state_t;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  pix_state_t pix_state, pix_next;
  acc_state_t acc_state, acc_next;

  logic [1:0]         lat_cnt;
  logic               done_sticky, err, irq_en, autoinc, page;
  logic [DONE_W-1:0]  done_code;
  logic [PIX_AW-1:0]  pix_ptr;
  logic [LAYER_W-1:0] layer;
  logic [15:0]        data_addr, weight_addr;

  logic        busy, pix_start, ptr_stall, rd_fire, wr_fire, pix_load;
  logic        go_req, set_done, set_err, clr_status;
  logic [31:0] wd32, rd32, pix_ext, ptr_w, data_w, weight_w;
  logic        unused_bits;

  // With an 8-bit bus the 16-bit fields are written a byte at a time;
  // CTRL bit7 selects the upper byte.
  function automatic logic [31:0] pg_wr(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic hi);
    logic [31:0] r;
    r = wd;
    if (DATA_W == 8) begin
      r = cur;
      if (hi) r[15:8] = wd[7:0];
      else    r[7:0]  = wd[7:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] pg_rd(input logic [31:0] cur, input logic hi);
    return (DATA_W == 8 && hi) ? (cur >> 8) : cur;
  endfunction

  assign busy       = (acc_state == ACC_GO) || (acc_state == ACC_BUSY);
  assign pix_start  = avs_chipselect && avs_read && (avs_address == 3'd3) && !busy &&
                      (pix_state == PIX_IDLE);
  // A PIX_PTR write cannot land while the pointer is still addressing memory.
  assign ptr_stall  = avs_chipselect && avs_write && (avs_address == 3'd2) &&
                      (pix_state != PIX_IDLE);
  assign avs_waitrequest = pix_start || (pix_state == PIX_WAIT) || ptr_stall;
  assign rd_fire    = avs_chipselect && avs_read && !avs_waitrequest && (pix_state == PIX_IDLE);
  assign wr_fire    = avs_chipselect && avs_write && !avs_waitrequest;
  assign pix_load   = (pix_state == PIX_WAIT) && (lat_cnt == 2'd0);
  assign go_req     = wr_fire && (avs_address == 3'd1) && wd32[0];
  assign set_done   = (acc_state == ACC_BUSY) && (acc_done != '0);
  assign set_err    = (go_req && (acc_state != ACC_IDLE)) ||
                      (rd_fire && (avs_address == 3'd3) && busy);
  assign clr_status = wr_fire && (avs_address == 3'd0) && wd32[1];

  assign pix_addr           = busy ? acc_image_idx : pix_ptr;
  assign irq                = done_sticky && irq_en;
  assign acc_layer_index    = layer;
  assign acc_data_address   = data_addr;
  assign acc_weight_address = weight_addr;

  always_comb begin
    wd32 = '0;
    wd32[DATA_W-1:0] = avs_writedata;
    pix_ext = '0;
    pix_ext[PIX_W-1:0] = pix_data;
    ptr_w    = pg_wr(32'(pix_ptr), wd32, page);
    data_w   = pg_wr({16'h0, data_addr}, wd32, page);
    weight_w = pg_wr({16'h0, weight_addr}, wd32, page);
  end

  assign unused_bits = ^{wd32[31:16], ptr_w[31:16], data_w[31:16], weight_w[31:16]};

  always_comb begin
    rd32 = '0;
    case (avs_address)
      3'd0: begin
        rd32[0] = busy;
        rd32[1] = done_sticky;
        rd32[2] = err;
        rd32[5 +: DONE_W] = done_code;
      end
      3'd1: begin
        rd32[1] = autoinc;
        rd32[2] = irq_en;
        rd32[7] = page;
      end
      3'd2: rd32 = pg_rd(32'(pix_ptr), page);
      3'd3: rd32 = '0;
      3'd4: rd32[LAYER_W-1:0] = layer;
      3'd5: rd32 = pg_rd({16'h0, data_addr}, page);
      3'd6: rd32 = pg_rd({16'h0, weight_addr}, page);
      default: rd32[7:0] = button_count;
    endcase
  end

  always_comb begin
    pix_next = pix_state;
    case (pix_state)
      PIX_IDLE: if (pix_start) pix_next = PIX_WAIT;
      PIX_WAIT: if (lat_cnt == 2'd0) pix_next = PIX_RESP;
      default:  pix_next = PIX_IDLE;
    endcase
  end

  always_comb begin
    acc_next = acc_state;
    acc_go   = 1'b0;
    case (acc_state)
      ACC_IDLE: if (go_req) acc_next = ACC_GO;
      ACC_GO: begin
        acc_go   = 1'b1;
        acc_next = ACC_BUSY;
      end
      ACC_BUSY: if (acc_done != '0) acc_next = ACC_DONE;
      default:  acc_next = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_state <= PIX_IDLE;
      acc_state <= ACC_IDLE;
      lat_cnt   <= '0;
    end else begin
      pix_state <= pix_next;
      acc_state <= acc_next;
      if (pix_start)                                   lat_cnt <= LAT_INIT;
      else if (pix_state == PIX_WAIT && lat_cnt != 0)  lat_cnt <= lat_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avs_readdata <= '0;
    else if (pix_load) avs_readdata <= pix_ext[DATA_W-1:0];
    else if (rd_fire)  avs_readdata <= rd32[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sticky <= 1'b0;
      err         <= 1'b0;
      done_code   <= '0;
      irq_en      <= 1'b0;
      autoinc     <= 1'b0;
      page        <= 1'b0;
      pix_ptr     <= '0;
      layer       <= '0;
      data_addr   <= '0;
      weight_addr <= '0;
    end else begin
      // A completing layer outranks a same-cycle clear.
      if (set_done) begin
        done_sticky <= 1'b1;
        done_code   <= acc_done;
      end else if (clr_status) begin
        done_sticky <= 1'b0;
      end
      if (set_err)         err <= 1'b1;
      else if (clr_status) err <= 1'b0;

      if (wr_fire && avs_address == 3'd1) begin
        irq_en  <= wd32[2];
        autoinc <= wd32[1];
        if (DATA_W == 8) page <= wd32[7];
      end

      if (wr_fire && avs_address == 3'd2)         pix_ptr <= ptr_w[PIX_AW-1:0];
      else if (pix_state == PIX_RESP && autoinc)  pix_ptr <= pix_ptr + PIX_AW'(1);

      // Accelerator configuration is frozen while a layer runs.
      if (wr_fire && !busy) begin
        case (avs_address)
          3'd4:    layer       <= wd32[LAYER_W-1:0];
          3'd5:    data_addr   <= data_w[15:0];
          3'd6:    weight_addr <= weight_w[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule
